ibus_responder: RTL

Instruction-bus responder: the memory side of the `ibus_req_t`/`ibus_resp_t` handshake that the fetch stage drives. It accepts one word-aligned instruction fetch at a time and returns the 32-bit instruction word from an internal word array after a fixed, parameterised latency. A side-band load port fills the array for boot and testbenches. It sits between the core's ibus port and the simulated memory system, and replaces the ideal zero-latency memory when testing pipeline stall behaviour.

---
 rtl/ibus_responder.sv | 100 ++++++++++
 1 files changed

// File: rtl/ibus_responder.sv
// Instruction-bus responder: accepts one word-aligned fetch at a time and returns
// the addressed word from an internal array after a fixed LATENCY.
package ibus_pkg;
  typedef logic [31:0] instr_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic   addr_ok;
    logic   data_ok;
    instr_t data;
  } ibus_resp_t;
endpackage

module ibus_responder
  import ibus_pkg::*;
#(
  parameter int          DEPTH     = 1024,
  parameter int          LATENCY   = 2,
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  ibus_req_t                ireq,
  output ibus_resp_t               iresp,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_idx,
  input  logic [31:0]              load_data
);

  localparam int          IW   = $clog2(DEPTH);
  localparam int          CW   = $clog2(LATENCY + 1);
  localparam logic [63:0] SPAN = 64'(DEPTH) << 2;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic          in_range;
  logic [63:0]   offset;
  logic          accept;
  logic [31:0]   mem [DEPTH];

  // Full-width subtraction: addresses below BASE_ADDR wrap high and fail the range test.
  assign offset = ireq.addr - BASE_ADDR;

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    iresp      = '0;
    case (state)
      IDLE: begin
        if (ireq.valid && !reset) begin
          accept     = 1'b1;
          state_next = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (cnt == CW'(1)) state_next = RESP;
      end
      RESP: begin
        iresp.data_ok = !reset;
        iresp.data    = (in_range && !reset) ? mem[idx] : 32'h0;
        state_next    = IDLE;
      end
      default: state_next = IDLE;
    endcase
    iresp.addr_ok = accept;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      idx      <= '0;
      in_range <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        idx      <= offset[IW+1:2];
        in_range <= (offset < SPAN);
        cnt      <= CW'(LATENCY - 1);
      end else if (state == WAIT) begin
        cnt <= cnt - CW'(1);
      end
    end
  end

  // NOTE: the word array is deliberately not reset; its contents survive reset.
  always_ff @(posedge clk) begin
    if (load_en) mem[load_idx] <= load_data;
  end

endmodule
